// File: rtl/bcd_rr_arbiter_if.sv
// Request/grant bundle between the ten requesters and the BCD round-robin arbiter.
// The arbiter sits on the slave side. The requester/testbench side uses the master modport.
interface bcd_rr_arbiter_if;
    logic [0:9] req;
    logic       done;
    logic [3:0] c;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  c,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output c,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/bcd_rr_arbiter.sv
// Ten-way round-robin arbiter with a BCD grant code, a bounded hold time and a mandatory gap cycle.
// The grant code feeds a one-hot decoder directly, so it never leaves the range 0..9.
module bcd_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    bcd_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] code;
    logic       grant;
    logic       tmo;
    logic [7:0] hold_cnt;
    logic       hold_limit;
    logic       release_req;

    // Search order: ptr, ptr+1, ..., 9, 0, ..., ptr-1.
    function automatic logic [3:0] rr_pick(input logic [0:9] r, input logic [3:0] p);
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = 4'd0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            idx = {1'b0, p} + 5'(k);
            if (idx > 5'd9) idx = idx - 5'd10;
            if (!found && r[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] next_ptr(input logic [3:0] cur);
        return (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
    endfunction

    assign hold_limit  = (hold_cnt == 8'(HOLD_MAX - 1));
    assign release_req = bus.done || !bus.req[code];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 4'd0;
            code     <= 4'd0;
            grant    <= 1'b0;
            tmo      <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    tmo <= 1'b0;
                    if (|bus.req) begin
                        code     <= rr_pick(bus.req, ptr);
                        grant    <= 1'b1;
                        hold_cnt <= 8'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_req || hold_limit) begin
                        grant <= 1'b0;
                        ptr   <= next_ptr(code);
                        // A voluntary release in the limit cycle is not a timeout.
                        tmo   <= hold_limit && !release_req;
                        state <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    tmo   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= 1'b0;
                    tmo   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.c         = code;
    assign bus.gnt_valid = grant;
    assign bus.timeout   = tmo;

endmodule

// File: doc/bcd_rr_arbiter.md
BCD_RR_ARBITER -- requirements
Module: bcd_rr_arbiter

Interface
REQ-001: Parameter HOLD_MAX, default 8: maximum cycles one grant is held before forced release; legal range 2..255.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: req  input  [0:9]  request lines; req[i] is requester i, bit order matching the decoder's [0:9] select outputs.
REQ-005: done  input  1  current owner releases the grant; sampled only in BUSY.
REQ-006: c  output  [3:0]  registered BCD code of the granted requester (0..9), driven straight into the one-hot decoder.
REQ-007: gnt_valid  output  1  registered; high while c names a live grant.
REQ-008: timeout  output  1  registered one-cycle pulse; grant forcibly ended by the HOLD_MAX limit.

Function
REQ-009: States: IDLE, BUSY, GAP; encoding is free, but no other reachable state exists.
REQ-010: Internal pointer ptr, 4 bits, range 0..9: the highest-priority requester for the next arbitration.
REQ-011: IDLE, no req bit set: stay in IDLE; gnt_valid=0; c holds its last value.
REQ-012: IDLE, any req bit set: next edge loads c with the first index i set in req, searching ptr, ptr+1, ... 9, 0, ... ptr-1; sets gnt_valid=1; clears hold counter; enters BUSY.
REQ-013: Grant latency is one cycle: req sampled at edge N gives gnt_valid=1 after edge N.
REQ-014: BUSY: hold counter increments every cycle; c and gnt_valid stay stable.
REQ-015: BUSY exits to GAP on the first of these:
- done=1
- req[c]=0 (requester withdrew)
- hold counter reaching HOLD_MAX-1
REQ-016: On the BUSY->GAP edge: gnt_valid=0; ptr = c+1 with wrap-around 9->0.
REQ-017: timeout=1 for exactly the GAP cycle only when the exit cause was the hold limit alone.
REQ-018: If done=1 or req[c]=0 in the same cycle the hold limit is reached: normal release, timeout stays 0.
REQ-019: GAP lasts exactly one cycle with gnt_valid=0, then returns to IDLE; no back-to-back grant without the gap.
REQ-020: Requests that change during BUSY or GAP have no effect until the next IDLE arbitration.
REQ-021: c never takes a value above 9, so the decoder never sees its default code while gnt_valid=1.
REQ-022: done asserted outside BUSY is ignored.

Reset
REQ-023: rst=1 immediately, without waiting for a clock edge, forces: state=IDLE, ptr=0, c=4'd0, gnt_valid=0, timeout=0, hold counter=0.
REQ-024: Reset asserted mid-BUSY drops gnt_valid within the same cycle; priority restarts at requester 0 after release.
REQ-025: First rising edge with rst=0 performs a normal IDLE evaluation.

Verification
REQ-026: After reset, req=10'b0000000001 (req[9] only): one edge later c=9, gnt_valid=1; done pulse -> GAP gnt_valid=0, ptr wraps to 0.
REQ-027: Fairness, req=all ones held, done pulsed each BUSY cycle: grant order c=0,1,2,...,9,0; every grant separated by one gnt_valid=0 cycle.
REQ-028: HOLD_MAX=8, req[3] held, done=0: gnt_valid high exactly 8 cycles, then timeout=1 for one cycle; next grant to requester 3 only if still requesting.
REQ-029: Simultaneous events, HOLD_MAX=8: done=1 on the 8th BUSY cycle -> release with timeout=0.
REQ-030: Reset mid-grant, c=5 and gnt_valid=1: rst pulsed between edges -> gnt_valid=0 and c=0 before the next edge; with req[4] and req[6] set, next grant is c=4.
